// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage; optional perf counters under FETCH_PERF_CNT_EN.
// Latency: FETCH+VALID >= 2 cycles per instruction; holds req/instr until imem_ready/dec_ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_imm,
  input  logic        redirect_is_jalr,
  input  logic        halt,
  output logic        is_halted,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] target_sum, target;

  // JALR clears bit 0 before the alignment check; bit 1 still faults.
  always_comb begin
    target_sum = redirect_base + redirect_imm;
    target     = {target_sum[31:1], target_sum[0] & ~redirect_is_jalr};
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          if (imem_rvalid) begin
            state_d    = S_VALID;
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d    = S_VALID;
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
        end
      end
      S_VALID: begin
        if (dec_ready) begin
          if (halt) begin
            state_d = S_HALTED;
          end else if (redirect) begin
            if (target[1:0] != 2'b00) begin
              misalign_d = 1'b1;
              state_d    = S_HALTED;
            end else begin
              pc_d    = target;
              state_d = S_FETCH;
            end
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req     = (state_q == S_FETCH);
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = (state_q == S_VALID);
  assign is_halted    = (state_q == S_HALTED);
  assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == S_VALID && dec_ready) retired_q <= retired_q + 32'd1;
      if ((state_q == S_FETCH && !imem_ready) || state_q == S_WAIT) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a transaction-level memory/consumer model predicts every cycle.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
  logic        redirect_is_jalr;
  logic        halt;
  logic        is_halted;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .dec_ready        (dec_ready),
    .redirect         (redirect),
    .redirect_base    (redirect_base),
    .redirect_imm     (redirect_imm),
    .redirect_is_jalr (redirect_is_jalr),
    .halt             (halt),
    .is_halted        (is_halted),
    .misalign_err     (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_retired     (perf_retired),
    .perf_stall       (perf_stall)
`endif
  );

  // Consumer decision for one presented instruction.
  typedef struct {
    int          dly;
    bit          hlt;
    bit          rd;
    logic [31:0] base;
    logic [31:0] imm;
    bit          jalr;
  } act_t;

  // Memory timing for one fetch.
  typedef struct {
    int rdy_dly;
    int lat;
    bit rst_in_wait;
  } mplan_t;

  act_t   act_q[$];
  mplan_t mp_q[$];
  act_t   cur_act;
  mplan_t cur_mp;

  int n_checks = 0;
  int n_errs   = 0;

  bit          m_in_reset, m_fetch, m_wait, m_present, m_halted, m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_retired, m_stall;
  int          rdy_cnt, wait_cnt, dec_cnt, halt_cycles, rst_pending, total_retired;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_mplan();
    if (mp_q.size() > 0) begin
      cur_mp = mp_q.pop_front();
    end else begin
      cur_mp.rdy_dly     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      cur_mp.lat         = int'($urandom_range(0, 2));
      cur_mp.rst_in_wait = 1'b0;
    end
    rdy_cnt = cur_mp.rdy_dly;
  endtask

  task automatic load_act();
    logic [31:0] r;
    int          s;
    if (act_q.size() > 0) begin
      cur_act = act_q.pop_front();
    end else begin
      r            = $urandom;
      s            = int'($urandom_range(0, 63));
      cur_act.dly  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      cur_act.hlt  = ($urandom_range(0, 39) == 0);
      cur_act.rd   = ($urandom_range(0, 2) == 0);
      cur_act.jalr = r[0];
      cur_act.base = r[0] ? ({r[31:3], 3'b000} + (r[2] ? 32'd1 : 32'd0)) : m_pc;
      cur_act.imm  = 32'(s * 4 - 128);
      if ($urandom_range(0, 7) == 0) cur_act.imm = cur_act.imm + $urandom_range(1, 3);
      if ($urandom_range(0, 5) == 0) begin
        cur_act.base = 32'hFFFF_FFF0;
        cur_act.imm  = 32'h0000_000C;
      end
    end
    dec_cnt = cur_act.dly;
  endtask

  // One cycle: check outputs against the model, choose next inputs, advance the model.
  task automatic tick();
    logic [31:0] tgt;
    if (m_in_reset) begin
      check_eq("rst_req",      32'(imem_req), 32'd0);
      check_eq("rst_addr",     imem_addr, RESET_PC);
      check_eq("rst_instr",    instr, 32'd0);
      check_eq("rst_instr_pc", instr_pc, RESET_PC);
      check_eq("rst_valid",    32'(instr_valid), 32'd0);
      check_eq("rst_halted",   32'(is_halted), 32'd0);
      check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    end else begin
      check_eq("req",      32'(imem_req), 32'(m_fetch));
      if (m_fetch) check_eq("addr", imem_addr, m_pc);
      check_eq("valid",    32'(instr_valid), 32'(m_present));
      if (m_present) begin
        check_eq("instr",    instr, mem_word(m_pc));
        check_eq("instr_pc", instr_pc, m_pc);
      end
      check_eq("halted",   32'(is_halted), 32'(m_halted));
      check_eq("misalign", 32'(misalign_err), 32'(m_mis));
    end
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_retired", perf_retired, m_retired);
    check_eq("perf_stall",   perf_stall, m_stall);
`endif

    imem_ready       = 1'b0;
    imem_rvalid      = 1'b0;
    imem_rdata       = $urandom;
    dec_ready        = 1'($urandom);
    redirect         = 1'($urandom);
    halt             = 1'($urandom);
    redirect_base    = $urandom;
    redirect_imm     = $urandom;
    redirect_is_jalr = 1'($urandom);

    if (rst_pending == 0 && !m_in_reset && act_q.size() == 0 && mp_q.size() == 0 &&
        $urandom_range(0, 299) == 0)
      rst_pending = 1;

    if (rst_pending > 0) begin
      rst_pending--;
      reset       = 1'b0;
      imem_ready  = 1'($urandom);
      imem_rvalid = 1'($urandom);
      m_in_reset  = 1'b1;
      m_fetch     = 1'b0;
      m_wait      = 1'b0;
      m_present   = 1'b0;
      m_halted    = 1'b0;
      m_mis       = 1'b0;
      m_pc        = RESET_PC;
      m_retired   = '0;
      m_stall     = '0;
      halt_cycles = 0;
    end else begin
      reset = 1'b1;
      if (m_in_reset) begin
        imem_rvalid = 1'b1;
        m_in_reset  = 1'b0;
        m_fetch     = 1'b1;
        load_mplan();
      end else if (m_fetch) begin
        if (rdy_cnt > 0) begin
          rdy_cnt--;
          m_stall++;
        end else begin
          imem_ready = 1'b1;
          m_fetch    = 1'b0;
          if (cur_mp.lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_pc);
            m_present   = 1'b1;
            load_act();
          end else begin
            m_wait   = 1'b1;
            wait_cnt = cur_mp.lat;
          end
        end
      end else if (m_wait) begin
        m_stall++;
        imem_ready = 1'($urandom);
        if (cur_mp.rst_in_wait) begin
          rst_pending        = 1;
          cur_mp.rst_in_wait = 1'b0;
        end
        if (wait_cnt == 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(m_pc);
          m_wait      = 1'b0;
          m_present   = 1'b1;
          load_act();
        end else begin
          wait_cnt--;
        end
      end else if (m_present) begin
        imem_rvalid = 1'($urandom);
        if (dec_cnt > 0) begin
          dec_cnt--;
          dec_ready = 1'b0;
        end else begin
          dec_ready        = 1'b1;
          halt             = cur_act.hlt;
          redirect         = cur_act.rd;
          redirect_base    = cur_act.base;
          redirect_imm     = cur_act.imm;
          redirect_is_jalr = cur_act.jalr;
          m_retired++;
          total_retired++;
          m_present = 1'b0;
          if (cur_act.hlt) begin
            m_halted = 1'b1;
          end else if (cur_act.rd) begin
            tgt = cur_act.base + cur_act.imm;
            if (cur_act.jalr) tgt = tgt & ~32'd1;
            if (tgt % 4 != 0) begin
              m_halted = 1'b1;
              m_mis    = 1'b1;
            end else begin
              m_pc = tgt;
            end
          end else begin
            m_pc = m_pc + 32'd4;
          end
          if (!m_halted) begin
            m_fetch = 1'b1;
            load_mplan();
          end
        end
      end else if (m_halted) begin
        imem_rvalid = 1'($urandom);
        halt_cycles++;
        if (halt_cycles >= 20) rst_pending = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b0;
    imem_ready       = 1'b0;
    imem_rvalid      = 1'b0;
    imem_rdata       = '0;
    dec_ready        = 1'b0;
    redirect         = 1'b0;
    halt             = 1'b0;
    redirect_base    = '0;
    redirect_imm     = '0;
    redirect_is_jalr = 1'b0;
    total_retired    = 0;

    // Zero-latency sequential run: 0,4,8,12.
    repeat (4) begin
      mp_q.push_back('{0, 0, 1'b0});
      act_q.push_back('{0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    end
    // Fetch at 0x10: ready low 3 cycles, rvalid 2 cycles after accept; then jump to 0x100.
    mp_q.push_back('{3, 2, 1'b0});
    act_q.push_back('{0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_00F0, 1'b0});
    // 0x100 held 4 cycles then backward branch to 0xF0; JALR to 0x2004; misaligned JALR to 0x2002.
    repeat (3) mp_q.push_back('{0, 0, 1'b0});
    act_q.push_back('{4, 1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFF0, 1'b0});
    act_q.push_back('{0, 1'b0, 1'b1, 32'h0000_2001, 32'h0000_0003, 1'b1});
    act_q.push_back('{0, 1'b0, 1'b1, 32'h0000_2001, 32'h0000_0001, 1'b1});
    // After reset: halt on first instruction.
    mp_q.push_back('{0, 0, 1'b0});
    act_q.push_back('{0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0});
    // After reset: reset lands mid-WAIT, stale rvalid in IDLE.
    mp_q.push_back('{0, 3, 1'b1});

    @(posedge clk);
    #1;
    m_in_reset  = 1'b1;
    m_fetch     = 1'b0;
    m_wait      = 1'b0;
    m_present   = 1'b0;
    m_halted    = 1'b0;
    m_mis       = 1'b0;
    m_pc        = RESET_PC;
    m_retired   = '0;
    m_stall     = '0;
    halt_cycles = 0;
    rst_pending = 2;

    for (int i = 0; i < 4000; i++) tick();

    check_eq("directed_consumed", 32'(act_q.size() + mp_q.size()), 32'd0);
    check_eq("progress", 32'(total_retired > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
